// File: rtl/ad9361_spi_arbiter.sv
// ad9361_spi_arbiter
// Round-robin arbiter that shares the AD9361 4-wire SPI port between NUM_REQ
// on-chip requesters. Each accepted request becomes one 24-bit single-byte
// register transaction (SPI mode 0, MSB first). Only one transaction is in
// flight at a time.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester request pending
//   req_ready  one-cycle accept pulse; req_data of that requester taken this cycle
//   req_data   requester i at [24*i+23:24*i] = {wr_n_rd, nb[2:0], rsvd[1:0], addr[9:0], wdata[7:0]}
//   rsp_valid  one-cycle completion pulse to the granted requester
//   rsp_data   read byte (8'h00 after a write), valid with rsp_valid
//   busy       high from accept until the chip-select gap has elapsed
//   spi_csn    chip select, active low
//   spi_clk    SPI clock, idles low
//   spi_mosi   serial data to the device
//   spi_miso   serial data from the device
//
// State table
//   state   | meaning
//   S_IDLE  | no transaction, arbitrate every cycle
//   S_ACPT  | req_ready pulse is out; latch the granted word, drop spi_csn
//   S_SETUP | spi_csn low, spi_clk low, first bit on spi_mosi
//   S_SHIFT | 24 bits, CLK_DIV cycles low then CLK_DIV cycles high each
//   S_HOLD  | spi_clk low, spi_csn still low; response on last cycle
//   S_GAP   | spi_csn high, busy; arbitrate on the last cycle
module ad9361_spi_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*24-1:0] req_data,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [7:0]            rsp_data,
  output logic                  busy,
  output logic                  spi_csn,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_A  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B  = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_LD = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W  = (MAX_LD > 1) ? $clog2(MAX_LD) : 1;

  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);

  // Clears nb and rsvd so every transaction is a single-byte access.
  localparam logic [23:0] WIRE_MASK = 24'h83FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACPT,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         bit_q, bit_d;
  logic               hi_q, hi_d;
  logic [23:0]        word_q, word_d;
  logic               wr_q, wr_d;
  logic [7:0]         rd_q, rd_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;
  logic               spi_csn_q, spi_csn_d;
  logic               spi_clk_q, spi_clk_d;
  logic               spi_mosi_q, spi_mosi_d;

  logic               arb_hit;
  logic [IDX_W-1:0]   arb_idx;
  logic               try_grant;
  logic [23:0]        sel_word;

  // Lowest requesting index at or above the pointer wins; otherwise wrap and
  // take the lowest requesting index below it.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!arb_hit && req_valid[j] && (IDX_W'(j) >= rr_q)) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!arb_hit && req_valid[j]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    hi_d        = hi_q;
    word_d      = word_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    spi_csn_d   = spi_csn_q;
    spi_clk_d   = spi_clk_q;
    spi_mosi_d  = spi_mosi_q;
    try_grant   = 1'b0;
    sel_word    = '0;

    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_q == IDX_W'(j)) sel_word = req_data[24*j +: 24];
    end

    unique case (state_q)
      S_IDLE: try_grant = 1'b1;
      S_ACPT: begin
        word_d     = sel_word & WIRE_MASK;
        wr_d       = sel_word[23];
        rd_d       = '0;
        spi_csn_d  = 1'b0;
        spi_mosi_d = sel_word[23];
        cnt_d      = SETUP_LD;
        state_d    = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          cnt_d   = DIV_LD;
          hi_d    = 1'b0;
          bit_d   = 5'd23;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SHIFT: begin
        // First cycle of the high phase is the one spi_clk rose on.
        if (hi_q && (cnt_q == DIV_LD)) rd_d = {rd_q[6:0], spi_miso};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!hi_q) begin
          hi_d      = 1'b1;
          spi_clk_d = 1'b1;
          cnt_d     = DIV_LD;
        end else begin
          hi_d      = 1'b0;
          spi_clk_d = 1'b0;
          if (bit_q == '0) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            bit_d      = bit_q - 1'b1;
            cnt_d      = DIV_LD;
            word_d     = {word_q[22:0], word_q[23]};
            spi_mosi_d = word_q[22];
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d    = S_GAP;
          cnt_d      = GAP_LD;
          spi_csn_d  = 1'b1;
          spi_mosi_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          try_grant = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Arbitrating in the last gap cycle lets back-to-back accepts land exactly
    // CS_GAP cycles after spi_csn rises.
    if (try_grant && arb_hit) begin
      state_d = S_ACPT;
      gnt_d   = arb_idx;
      busy_d  = 1'b1;
      rr_d    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      for (int j = 0; j < NUM_REQ; j++) begin
        req_ready_d[j] = (arb_idx == IDX_W'(j));
      end
    end

    if ((state_d == S_HOLD) && (cnt_d == '0)) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        rsp_valid_d[j] = (gnt_q == IDX_W'(j));
      end
      rsp_data_d = wr_q ? 8'h00 : rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      hi_q        <= 1'b0;
      word_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      gnt_q       <= '0;
      rr_q        <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      spi_csn_q   <= 1'b1;
      spi_clk_q   <= 1'b0;
      spi_mosi_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      hi_q        <= hi_d;
      word_q      <= word_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      spi_csn_q   <= spi_csn_d;
      spi_clk_q   <= spi_clk_d;
      spi_mosi_q  <= spi_mosi_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign spi_csn   = spi_csn_q;
  assign spi_clk   = spi_clk_q;
  assign spi_mosi  = spi_mosi_q;

endmodule
